// File: rtl/key_schedule_engine.sv
// Word-serial AES key expansion (128/192/256) into an internal round-key store.
// Round keys are read back by round index with RD_REG cycles of latency.

module s_box_enc (
  input  logic [7:0] i_Byte,
  output logic [7:0] o_Byte
);
  // Forward S-box computed as GF(2^8) inverse (x^254) followed by the affine map.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] x2, x3, x6, x12, x15, x240, inv;

  always_comb begin
    x2   = gf_mul(i_Byte, i_Byte);
    x3   = gf_mul(x2, i_Byte);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x240 = x15;
    for (int k = 0; k < 4; k++) x240 = gf_mul(x240, x240);
    inv  = gf_mul(gf_mul(x240, x12), x2);
    o_Byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module key_schedule_engine #(
  parameter int MAX_NR = 14,
  parameter int RD_REG = 1
) (
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic         i_Start,
  input  logic [255:0] i_Key,
  input  logic [1:0]   i_Key_Mode,
  output logic         o_Busy,
  output logic         o_Done,
  output logic         o_Keys_Valid,
  output logic         o_Key_Err,
  output logic [3:0]   o_Nr,
  input  logic         i_Rd_En,
  input  logic [3:0]   i_Rd_Round,
  output logic [127:0] o_Rd_Key,
  output logic         o_Rd_Valid,
  output logic [1:0]   o_State
);
  localparam int STORE_W = 4 * (MAX_NR + 1);

  typedef enum logic [1:0] {IDLE, LOAD, GEN, FIN} state_t;

  state_t      state, state_nxt;
  logic [31:0] store [STORE_W];
  logic [31:0] win [8];
  logic [3:0]  nk, nr;
  logic [5:0]  widx, last_idx;
  logic [2:0]  jmod;
  logic [7:0]  rcon;
  logic        mode_ok, accept, reject;
  logic [31:0] prev, sub_in, sub_out, temp, old_word, new_word;
  logic        rd_ok;
  logic [5:0]  rd_base;
  logic [127:0] rd_word;

  always_comb begin
    case (i_Key_Mode)
      2'b00:   mode_ok = 1'b1;
      2'b01:   mode_ok = (MAX_NR >= 12);
      default: mode_ok = (MAX_NR >= 14);
    endcase
  end

  assign last_idx = {nr, 2'b00} + 6'd3;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    reject    = 1'b0;
    case (state)
      IDLE: if (i_Start) begin
        if (mode_ok) begin
          accept    = 1'b1;
          state_nxt = LOAD;
        end else begin
          reject = 1'b1;
        end
      end
      LOAD:    state_nxt = GEN;
      GEN:     if (widx == last_idx) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign o_Busy  = (state == LOAD) || (state == GEN);
  assign o_Done  = (state == FIN);
  assign o_State = state;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state        <= IDLE;
      o_Keys_Valid <= 1'b0;
      o_Nr         <= 4'd0;
      o_Key_Err    <= 1'b0;
      nk           <= 4'd4;
      nr           <= 4'd10;
      widx         <= 6'd0;
      jmod         <= 3'd0;
      rcon         <= 8'h01;
    end else begin
      state     <= state_nxt;
      o_Key_Err <= reject;
      if (accept) begin
        o_Keys_Valid <= 1'b0;
        case (i_Key_Mode)
          2'b00:   begin nk <= 4'd4; nr <= 4'd10; end
          2'b01:   begin nk <= 4'd6; nr <= 4'd12; end
          default: begin nk <= 4'd8; nr <= 4'd14; end
        endcase
      end
      if (state == LOAD) begin
        widx <= {2'b00, nk};
        jmod <= 3'd0;
        rcon <= 8'h01;
      end
      if (state == GEN) begin
        widx <= widx + 6'd1;
        jmod <= (jmod == nk[2:0] - 3'd1) ? 3'd0 : jmod + 3'd1;
        if (jmod == 3'd0) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        if (state_nxt == FIN) begin
          o_Keys_Valid <= 1'b1;
          o_Nr         <= nr;
        end
      end
    end
  end

  // win[7] is w[i-1]; w[i-Nk] sits at win[8-Nk]. jmod tracks i mod Nk.
  assign prev   = win[7];
  assign sub_in = (jmod == 3'd0) ? {prev[23:0], prev[31:24]} : prev;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    s_box_enc u_sbox (.i_Byte(sub_in[8*b +: 8]), .o_Byte(sub_out[8*b +: 8]));
  end

  always_comb begin
    temp = prev;
    if (jmod == 3'd0)                    temp = sub_out ^ {rcon, 24'h0};
    else if (nk == 4'd8 && jmod == 3'd4) temp = sub_out;
    case (nk)
      4'd4:    old_word = win[4];
      4'd6:    old_word = win[2];
      default: old_word = win[0];
    endcase
    new_word = old_word ^ temp;
  end

  // A right-justified key lands so that its last word is always win[7].
  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      if (accept) begin
        for (int m = 0; m < 8; m++) win[m] <= i_Key[255 - 32*m -: 32];
      end else if (state == GEN) begin
        for (int m = 0; m < 7; m++) win[m] <= win[m+1];
        win[7]      <= new_word;
        store[widx] <= new_word;
      end
      if (state == LOAD) begin
        case (nk)
          4'd4:    for (int k = 0; k < 4; k++) store[k] <= win[k+4];
          4'd6:    for (int k = 0; k < 6; k++) store[k] <= win[k+2];
          default: for (int k = 0; k < 8; k++) store[k] <= win[k];
        endcase
      end
    end
  end

  // Reads have no backpressure: each i_Rd_En cycle is one request, and
  // o_Rd_Valid qualifies o_Rd_Key RD_REG cycles later (zero key when invalid).
  assign rd_ok   = i_Rd_En & o_Keys_Valid & (i_Rd_Round <= o_Nr);
  assign rd_base = rd_ok ? {i_Rd_Round, 2'b00} : 6'd0;
  assign rd_word = rd_ok ? {store[rd_base], store[rd_base + 6'd1],
                            store[rd_base + 6'd2], store[rd_base + 6'd3]} : 128'd0;

  if (RD_REG != 0) begin : g_rd_reg
    always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
        o_Rd_Valid <= 1'b0;
        o_Rd_Key   <= 128'd0;
      end else begin
        o_Rd_Valid <= rd_ok;
        o_Rd_Key   <= rd_word;
      end
    end
  end else begin : g_rd_comb
    assign o_Rd_Valid = rd_ok;
    assign o_Rd_Key   = rd_word;
  end
endmodule

// File: tb/tb_key_schedule_engine.sv
// Bench for key_schedule_engine: FIPS-197 vectors, timing, protocol corners,
// reset abort and MAX_NR=10 key rejection, against an independent expansion model.

module tb_key_schedule_engine;
  logic         i_Clk = 1'b0;
  logic         i_Rst, i_Start, i_Rd_En;
  logic [255:0] i_Key;
  logic [1:0]   i_Key_Mode;
  logic [3:0]   i_Rd_Round;
  logic         o_Busy, o_Done, o_Keys_Valid, o_Key_Err, o_Rd_Valid;
  logic [3:0]   o_Nr;
  logic [127:0] o_Rd_Key;
  logic [1:0]   o_State;

  logic         b_Start, b_Rd_En;
  logic [255:0] b_Key;
  logic [1:0]   b_Key_Mode;
  logic [3:0]   b_Rd_Round;
  logic         b_Busy, b_Done, b_Keys_Valid, b_Key_Err, b_Rd_Valid;
  logic [3:0]   b_Nr;
  logic [127:0] b_Rd_Key;
  logic [1:0]   b_State;

  int n_checks = 0;
  int n_fail   = 0;
  logic [127:0] exp_q[$];
  logic         expv_q[$];
  logic [31:0]  mw[60];

  localparam logic [255:0] K128 = 256'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] K192 = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic [2047:0] sbox_bits = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  key_schedule_engine #(.MAX_NR(14), .RD_REG(1)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Start(i_Start), .i_Key(i_Key), .i_Key_Mode(i_Key_Mode),
    .o_Busy(o_Busy), .o_Done(o_Done), .o_Keys_Valid(o_Keys_Valid), .o_Key_Err(o_Key_Err),
    .o_Nr(o_Nr), .i_Rd_En(i_Rd_En), .i_Rd_Round(i_Rd_Round), .o_Rd_Key(o_Rd_Key),
    .o_Rd_Valid(o_Rd_Valid), .o_State(o_State));

  key_schedule_engine #(.MAX_NR(10), .RD_REG(0)) dut10 (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Start(b_Start), .i_Key(b_Key), .i_Key_Mode(b_Key_Mode),
    .o_Busy(b_Busy), .o_Done(b_Done), .o_Keys_Valid(b_Keys_Valid), .o_Key_Err(b_Key_Err),
    .o_Nr(b_Nr), .i_Rd_En(b_Rd_En), .i_Rd_Round(b_Rd_Round), .o_Rd_Key(b_Rd_Key),
    .o_Rd_Valid(b_Rd_Valid), .o_State(b_State));

  always #5 i_Clk = ~i_Clk;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    int idx;
    idx = 2047 - 8 * int'(b);
    return sbox_bits[idx -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon_of(input int n);
    case (n)
      1: return 8'h01;  2: return 8'h02;  3: return 8'h04;  4: return 8'h08;
      5: return 8'h10;  6: return 8'h20;  7: return 8'h40;  8: return 8'h80;
      9: return 8'h1b; 10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_expand(input logic [255:0] key, input int nk, input int nr);
    logic [31:0] t;
    for (int k = 0; k < nk; k++) mw[k] = key[32*(nk-k)-1 -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = mw[i-1];
      if (i % nk == 0)                t = sub_word({t[23:0], t[31:24]}) ^ {rcon_of(i/nk), 24'h0};
      else if (nk == 8 && i % 8 == 4) t = sub_word(t);
      mw[i] = mw[i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] model_round(input int r);
    return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
  endfunction

  task automatic read_check(input int r, input logic en, input logic exp_v,
                            input logic [127:0] exp_k, input string name);
    logic [127:0] ek;
    logic         ev;
    @(negedge i_Clk);
    i_Rd_En = en;
    i_Rd_Round = 4'(r);
    exp_q.push_back(exp_k);
    expv_q.push_back(exp_v);
    @(posedge i_Clk); #1;
    ek = exp_q.pop_front();
    ev = expv_q.pop_front();
    n_checks++;
    if (o_Rd_Valid !== ev || o_Rd_Key !== ek) begin
      n_fail++;
      $display("FAIL %s round %0d: got valid=%b key=%h, expected valid=%b key=%h",
               name, r, o_Rd_Valid, o_Rd_Key, ev, ek);
    end
  endtask

  task automatic read_all_rounds(input int nr, input string name);
    for (int r = 0; r <= nr; r++) read_check(r, 1'b1, 1'b1, model_round(r), name);
    @(negedge i_Clk);
    i_Rd_En = 1'b0;
  endtask

  task automatic run_expansion(input logic [255:0] key, input logic [1:0] mode, input int exp_cycles,
                               input logic [3:0] exp_nr, input int restart_at,
                               input logic start_on_done, input string name);
    int   cycles;
    logic done_seen;
    @(negedge i_Clk);
    i_Key = key; i_Key_Mode = mode; i_Start = 1'b1;
    cycles = 0; done_seen = 1'b0;
    while (!done_seen && cycles < 200) begin
      @(posedge i_Clk); #1;
      cycles++;
      if (cycles == 1) begin
        n_checks++;
        if (o_Busy !== 1'b1 || o_Keys_Valid !== 1'b0) begin
          n_fail++;
          $display("FAIL %s accept: got busy=%b keys_valid=%b, expected 1/0", name, o_Busy, o_Keys_Valid);
        end
      end
      if (o_Done === 1'b1) done_seen = 1'b1;
      @(negedge i_Clk);
      i_Start = 1'b0; i_Key = key; i_Key_Mode = mode;
      if (restart_at != 0 && cycles == restart_at) begin
        i_Start = 1'b1; i_Key = ~key; i_Key_Mode = 2'b11;
      end
    end
    n_checks++;
    if (!done_seen || cycles != exp_cycles) begin
      n_fail++;
      $display("FAIL %s done_latency: got %0d cycles (seen=%b), expected %0d", name, cycles, done_seen, exp_cycles);
    end
    n_checks++;
    if (o_Done !== 1'b1 || o_Busy !== 1'b0 || o_Keys_Valid !== 1'b1 || o_Nr !== exp_nr) begin
      n_fail++;
      $display("FAIL %s done_state: got done=%b busy=%b valid=%b nr=%0d, expected 1/0/1/%0d",
               name, o_Done, o_Busy, o_Keys_Valid, o_Nr, exp_nr);
    end
    i_Start = start_on_done;
    @(posedge i_Clk); #1;
    n_checks++;
    if (o_Done !== 1'b0 || o_Busy !== 1'b0 || o_Keys_Valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s after_done: got done=%b busy=%b valid=%b, expected 0/0/1", name, o_Done, o_Busy, o_Keys_Valid);
    end
    @(negedge i_Clk);
    i_Start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    n_checks++;
    if (o_Busy !== 1'b0 || o_Done !== 1'b0 || o_Keys_Valid !== 1'b0 || o_Key_Err !== 1'b0 ||
        o_Nr !== 4'd0 || o_Rd_Valid !== 1'b0 || o_Rd_Key !== 128'd0 || o_State !== 2'd0) begin
      n_fail++;
      $display("FAIL %s: got busy=%b done=%b valid=%b err=%b nr=%0d rdv=%b key=%h state=%0d, expected all zero",
               name, o_Busy, o_Done, o_Keys_Valid, o_Key_Err, o_Nr, o_Rd_Valid, o_Rd_Key, o_State);
    end
  endtask

  task automatic test_reset();
    i_Rst = 1'b1; i_Start = 1'b0; i_Key = '0; i_Key_Mode = 2'b00; i_Rd_En = 1'b0; i_Rd_Round = 4'd0;
    b_Start = 1'b0; b_Key = '0; b_Key_Mode = 2'b00; b_Rd_En = 1'b0; b_Rd_Round = 4'd0;
    repeat (3) @(posedge i_Clk);
    #1;
    check_reset_outputs("reset");
    @(negedge i_Clk);
    i_Rst = 1'b0;
  endtask

  task automatic test_aes128();
    model_expand(K128, 4, 10);
    run_expansion(K128, 2'b00, 42, 4'd10, 0, 1'b0, "aes128");
    read_check(0, 1'b1, 1'b1, K128[127:0], "aes128_r0");
    read_check(1, 1'b1, 1'b1, 128'ha0fafe1788542cb123a339392a6c7605, "aes128_r1");
    read_check(10, 1'b1, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "aes128_r10");
    read_check(13, 1'b1, 1'b0, 128'd0, "aes128_r13_out_of_range");
    read_check(3, 1'b0, 1'b0, 128'd0, "aes128_rd_en_low");
    read_all_rounds(10, "aes128_model");
  endtask

  task automatic test_restart_ignored();
    run_expansion(K128, 2'b00, 42, 4'd10, 5, 1'b1, "restart");
    read_check(10, 1'b1, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "restart_r10");
    read_all_rounds(10, "restart_model");
  endtask

  task automatic test_aes192();
    model_expand(K192, 6, 12);
    run_expansion(K192, 2'b01, 48, 4'd12, 0, 1'b0, "aes192");
    read_check(0, 1'b1, 1'b1, 128'h8e73b0f7da0e6452c810f32b809079e5, "aes192_r0");
    read_check(12, 1'b1, 1'b1, 128'he98ba06f448c773c8ecc720401002202, "aes192_r12");
    read_check(13, 1'b1, 1'b0, 128'd0, "aes192_r13_out_of_range");
    read_all_rounds(12, "aes192_model");
  endtask

  task automatic test_aes256();
    model_expand(K256, 8, 14);
    run_expansion(K256, 2'b11, 54, 4'd14, 0, 1'b0, "aes256");
    read_check(0, 1'b1, 1'b1, K256[255:128], "aes256_r0");
    read_check(1, 1'b1, 1'b1, K256[127:0], "aes256_r1");
    read_check(14, 1'b1, 1'b1, 128'hfe4890d1e6188d0b046df344706c631e, "aes256_r14");
    read_check(15, 1'b1, 1'b0, 128'd0, "aes256_r15_out_of_range");
    read_all_rounds(14, "aes256_model");
  endtask

  task automatic test_reset_mid_gen();
    @(negedge i_Clk);
    i_Key = K128; i_Key_Mode = 2'b00; i_Start = 1'b1;
    @(posedge i_Clk);
    @(negedge i_Clk);
    i_Start = 1'b0;
    repeat (10) @(posedge i_Clk);
    @(negedge i_Clk);
    i_Rd_En = 1'b1; i_Rd_Round = 4'd0;
    @(posedge i_Clk); #1;
    n_checks++;
    if (o_Rd_Valid !== 1'b0 || o_Rd_Key !== 128'd0 || o_Keys_Valid !== 1'b0 ||
        o_Busy !== 1'b1 || o_State !== 2'd2) begin
      n_fail++;
      $display("FAIL read_during_gen: got rdv=%b key=%h valid=%b busy=%b state=%0d, expected 0/0/0/1/2",
               o_Rd_Valid, o_Rd_Key, o_Keys_Valid, o_Busy, o_State);
    end
    @(negedge i_Clk);
    i_Rd_En = 1'b0;
    repeat (9) @(posedge i_Clk);
    @(negedge i_Clk);
    i_Rst = 1'b1;
    @(posedge i_Clk); #1;
    check_reset_outputs("reset_mid_gen");
    @(negedge i_Clk);
    i_Rst = 1'b0;
    model_expand(K128, 4, 10);
    run_expansion(K128, 2'b00, 42, 4'd10, 0, 1'b0, "fresh128");
    read_check(1, 1'b1, 1'b1, 128'ha0fafe1788542cb123a339392a6c7605, "fresh128_r1");
    read_check(10, 1'b1, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "fresh128_r10");
    @(negedge i_Clk);
    i_Rd_En = 1'b0;
  endtask

  task automatic test_max_nr10();
    int   cycles;
    logic seen;
    logic [127:0] ek;
    logic ev;
    @(negedge i_Clk);
    b_Key = K128; b_Key_Mode = 2'b00; b_Start = 1'b1;
    cycles = 0; seen = 1'b0;
    while (!seen && cycles < 200) begin
      @(posedge i_Clk); #1;
      cycles++;
      if (b_Done === 1'b1) seen = 1'b1;
      @(negedge i_Clk);
      b_Start = 1'b0;
    end
    n_checks++;
    if (!seen || cycles != 42) begin
      n_fail++;
      $display("FAIL nr10_aes128_latency: got %0d cycles (seen=%b), expected 42", cycles, seen);
    end
    for (int m = 1; m <= 2; m++) begin
      @(negedge i_Clk);
      b_Start = 1'b1; b_Key = K256; b_Key_Mode = (m == 1) ? 2'b10 : 2'b01;
      @(posedge i_Clk); #1;
      n_checks++;
      if (b_Key_Err !== 1'b1 || b_Busy !== 1'b0) begin
        n_fail++;
        $display("FAIL nr10_key_err mode=%0d: got err=%b busy=%b, expected 1/0", m, b_Key_Err, b_Busy);
      end
      @(negedge i_Clk);
      b_Start = 1'b0;
      @(posedge i_Clk); #1;
      n_checks++;
      if (b_Key_Err !== 1'b0 || b_Keys_Valid !== 1'b1 || b_Nr !== 4'd10) begin
        n_fail++;
        $display("FAIL nr10_after_err mode=%0d: got err=%b valid=%b nr=%0d, expected 0/1/10",
                 m, b_Key_Err, b_Keys_Valid, b_Nr);
      end
    end
    for (int r = 9; r <= 11; r++) begin
      @(negedge i_Clk);
      b_Rd_En = 1'b1; b_Rd_Round = 4'(r);
      exp_q.push_back((r <= 10) ? model_round(r) : 128'd0);
      expv_q.push_back(r <= 10);
      #1;
      ek = exp_q.pop_front();
      ev = expv_q.pop_front();
      n_checks++;
      if (b_Rd_Valid !== ev || b_Rd_Key !== ek) begin
        n_fail++;
        $display("FAIL nr10_comb_read round %0d: got valid=%b key=%h, expected valid=%b key=%h",
                 r, b_Rd_Valid, b_Rd_Key, ev, ek);
      end
    end
    @(negedge i_Clk);
    b_Rd_En = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_aes128();
    test_restart_ignored();
    test_aes192();
    test_aes256();
    test_reset_mid_gen();
    test_max_nr10();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
